// File: rtl/oled_spi_sink_if.sv
// ST7735 4-wire SPI bus plus the decoded byte/command/pixel event outputs of the sink.
interface oled_spi_sink_if;
  logic        spi_csn;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_dc;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_dc;
  logic        cmd_valid;
  logic [7:0]  cmd;
  logic        pixel_valid;
  logic [7:0]  pixel_x;
  logic [7:0]  pixel_y;
  logic [15:0] pixel_color;

  modport master (
    output spi_csn, spi_clk, spi_mosi, spi_dc,
    input  byte_valid, byte_data, byte_dc, cmd_valid, cmd,
    input  pixel_valid, pixel_x, pixel_y, pixel_color
  );

  modport slave (
    input  spi_csn, spi_clk, spi_mosi, spi_dc,
    output byte_valid, byte_data, byte_dc, cmd_valid, cmd,
    output pixel_valid, pixel_x, pixel_y, pixel_color
  );
endinterface

// File: rtl/oled_spi_sink.sv
// ST7735 display-side SPI sink: oversamples the bus, assembles bytes, decodes CASET/RASET/RAMWR.
// byte_valid lands C_sync+2 clk after the 8th SPI rising edge; no backpressure, events are strobes.
module oled_spi_sink #(
  parameter int C_x_size = 80,
  parameter int C_y_size = 160,
  parameter int C_sync   = 2
) (
  input  logic           clk,
  input  logic           reset,
  oled_spi_sink_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CASET = 2'd1,
    ST_RASET = 2'd2,
    ST_RAMWR = 2'd3
  } state_t;

  localparam logic [7:0] XE_DEF = 8'(C_x_size - 1);
  localparam logic [7:0] YE_DEF = 8'(C_y_size - 1);

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  // input synchronisers
  logic [C_sync-1:0] csn_sync_q,  csn_sync_d;
  logic [C_sync-1:0] clk_sync_q,  clk_sync_d;
  logic [C_sync-1:0] mosi_sync_q, mosi_sync_d;
  logic [C_sync-1:0] dc_sync_q,   dc_sync_d;

  // edge detect and sampled bit
  logic clk_prev_q, clk_prev_d;
  logic rise_q,     rise_d;
  logic csn_q,      csn_d;
  logic mosi_q,     mosi_d;
  logic dc_q,       dc_d;

  // byte assembly
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q,   shift_d;

  // registered outputs
  logic        byte_valid_q,  byte_valid_d;
  logic [7:0]  byte_data_q,   byte_data_d;
  logic        byte_dc_q,     byte_dc_d;
  logic        cmd_valid_q,   cmd_valid_d;
  logic [7:0]  cmd_q,         cmd_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic [7:0]  pixel_x_q,     pixel_x_d;
  logic [7:0]  pixel_y_q,     pixel_y_d;
  logic [15:0] pixel_color_q, pixel_color_d;

  // decoder state
  state_t     state_q,     state_d;
  logic [1:0] arg_idx_q,   arg_idx_d;
  logic [7:0] arg_start_q, arg_start_d;
  logic [7:0] xs_q, xs_d, xe_q, xe_d;
  logic [7:0] ys_q, ys_d, ye_q, ye_d;
  logic [7:0] cur_x_q, cur_x_d;
  logic [7:0] cur_y_q, cur_y_d;
  logic       pix_phase_q, pix_phase_d;
  logic [7:0] pix_hi_q,    pix_hi_d;

  logic [7:0] new_byte;
  logic       got_byte;

  always_comb begin
    csn_sync_d  = {csn_sync_q[C_sync-2:0],  bus.spi_csn};
    clk_sync_d  = {clk_sync_q[C_sync-2:0],  bus.spi_clk};
    mosi_sync_d = {mosi_sync_q[C_sync-2:0], bus.spi_mosi};
    dc_sync_d   = {dc_sync_q[C_sync-2:0],   bus.spi_dc};

    clk_prev_d = clk_sync_q[C_sync-1];
    rise_d     = clk_sync_q[C_sync-1] & ~clk_prev_q & ~csn_sync_q[C_sync-1];
    csn_d      = csn_sync_q[C_sync-1];
    mosi_d     = mosi_sync_q[C_sync-1];
    dc_d       = dc_sync_q[C_sync-1];

    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;

    byte_valid_d  = 1'b0;
    byte_data_d   = byte_data_q;
    byte_dc_d     = byte_dc_q;
    cmd_valid_d   = 1'b0;
    cmd_d         = cmd_q;
    pixel_valid_d = 1'b0;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    pixel_color_d = pixel_color_q;

    state_d     = state_q;
    arg_idx_d   = arg_idx_q;
    arg_start_d = arg_start_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ys_d        = ys_q;
    ye_d        = ye_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    pix_phase_d = pix_phase_q;
    pix_hi_d    = pix_hi_q;

    new_byte = {shift_q, mosi_q};
    got_byte = 1'b0;

    // rise_q and csn_q come from the same sample, so they never overlap
    if (rise_q) begin
      if (bit_cnt_q == 3'd7) begin
        bit_cnt_d    = 3'd0;
        byte_valid_d = 1'b1;
        byte_data_d  = new_byte;
        byte_dc_d    = dc_q;
        got_byte     = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        shift_d   = new_byte[6:0];
      end
    end else if (csn_q) begin
      bit_cnt_d = 3'd0;
      shift_d   = 7'd0;
    end

    if (got_byte && !dc_q) begin
      cmd_d       = new_byte;
      cmd_valid_d = 1'b1;
      arg_idx_d   = 2'd0;
      pix_phase_d = 1'b0;
      case (new_byte)
        CMD_CASET: state_d = ST_CASET;
        CMD_RASET: state_d = ST_RASET;
        CMD_RAMWR: begin
          state_d   = ST_RAMWR;
          pixel_x_d = xs_q;
          pixel_y_d = ys_q;
          cur_x_d   = xs_q;
          cur_y_d   = ys_q;
        end
        CMD_SWRESET: begin
          state_d = ST_IDLE;
          xs_d    = 8'd0;
          xe_d    = XE_DEF;
          ys_d    = 8'd0;
          ye_d    = YE_DEF;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (got_byte) begin
      case (state_q)
        ST_CASET, ST_RASET: begin
          // only the low bytes carry coordinates; the window commits on the 4th argument
          arg_idx_d = arg_idx_q + 2'd1;
          if (arg_idx_q == 2'd1) begin
            arg_start_d = new_byte;
          end
          if (arg_idx_q == 2'd3) begin
            if (state_q == ST_CASET) begin
              xs_d = arg_start_q;
              xe_d = new_byte;
            end else begin
              ys_d = arg_start_q;
              ye_d = new_byte;
            end
            state_d = ST_IDLE;
          end
        end
        ST_RAMWR: begin
          if (!pix_phase_q) begin
            pix_hi_d    = new_byte;
            pix_phase_d = 1'b1;
          end else begin
            pix_phase_d   = 1'b0;
            pixel_valid_d = 1'b1;
            pixel_color_d = {pix_hi_q, new_byte};
            pixel_x_d     = cur_x_q;
            pixel_y_d     = cur_y_q;
            if (cur_x_q != xe_q) begin
              cur_x_d = cur_x_q + 8'd1;
            end else begin
              cur_x_d = xs_q;
              cur_y_d = (cur_y_q == ye_q) ? ys_q : cur_y_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csn_sync_q    <= '1;
      clk_sync_q    <= '0;
      mosi_sync_q   <= '0;
      dc_sync_q     <= '0;
      clk_prev_q    <= 1'b0;
      rise_q        <= 1'b0;
      csn_q         <= 1'b1;
      mosi_q        <= 1'b0;
      dc_q          <= 1'b0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 7'd0;
      byte_valid_q  <= 1'b0;
      byte_data_q   <= 8'd0;
      byte_dc_q     <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_q         <= 8'd0;
      pixel_valid_q <= 1'b0;
      pixel_x_q     <= 8'd0;
      pixel_y_q     <= 8'd0;
      pixel_color_q <= 16'd0;
      state_q       <= ST_IDLE;
      arg_idx_q     <= 2'd0;
      arg_start_q   <= 8'd0;
      xs_q          <= 8'd0;
      xe_q          <= XE_DEF;
      ys_q          <= 8'd0;
      ye_q          <= YE_DEF;
      cur_x_q       <= 8'd0;
      cur_y_q       <= 8'd0;
      pix_phase_q   <= 1'b0;
      pix_hi_q      <= 8'd0;
    end else begin
      csn_sync_q    <= csn_sync_d;
      clk_sync_q    <= clk_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      dc_sync_q     <= dc_sync_d;
      clk_prev_q    <= clk_prev_d;
      rise_q        <= rise_d;
      csn_q         <= csn_d;
      mosi_q        <= mosi_d;
      dc_q          <= dc_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      byte_valid_q  <= byte_valid_d;
      byte_data_q   <= byte_data_d;
      byte_dc_q     <= byte_dc_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_q         <= cmd_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      pixel_color_q <= pixel_color_d;
      state_q       <= state_d;
      arg_idx_q     <= arg_idx_d;
      arg_start_q   <= arg_start_d;
      xs_q          <= xs_d;
      xe_q          <= xe_d;
      ys_q          <= ys_d;
      ye_q          <= ye_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      pix_phase_q   <= pix_phase_d;
      pix_hi_q      <= pix_hi_d;
    end
  end

  assign bus.byte_valid  = byte_valid_q;
  assign bus.byte_data   = byte_data_q;
  assign bus.byte_dc     = byte_dc_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd         = cmd_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.pixel_x     = pixel_x_q;
  assign bus.pixel_y     = pixel_y_q;
  assign bus.pixel_color = pixel_color_q;

endmodule

// File: tb/tb_oled_spi_sink.sv
// Directed bench for oled_spi_sink: byte table with expected decode results plus window-wrap and reset sequences.
module tb_oled_spi_sink;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  oled_spi_sink_if bus();

  oled_spi_sink #(.C_x_size(80), .C_y_size(160), .C_sync(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // event monitor, sampled on the falling edge
  int          n_byte = 0, n_cmd = 0, n_pix = 0, bv_cyc = 0, tx_cyc = 0;
  logic        s_cmd_v, s_pix_v, s_dc;
  logic [7:0]  s_data, s_cmd, s_x, s_y;
  logic [15:0] s_col;

  always @(negedge clk) begin
    if (bus.byte_valid) begin
      n_byte  <= n_byte + 1;
      bv_cyc  <= cyc;
      s_data  <= bus.byte_data;
      s_dc    <= bus.byte_dc;
      s_cmd_v <= bus.cmd_valid;
      s_cmd   <= bus.cmd;
      s_pix_v <= bus.pixel_valid;
      s_x     <= bus.pixel_x;
      s_y     <= bus.pixel_y;
      s_col   <= bus.pixel_color;
    end
    if (bus.cmd_valid)   n_cmd <= n_cmd + 1;
    if (bus.pixel_valid) n_pix <= n_pix + 1;
  end

  int tests = 0, fails = 0;

  task automatic check(input string name, input int idx, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // SPI clock is clk/4; csn is raised after every transfer
  task automatic send_bits(input logic [7:0] d, input logic dcv, input int nb);
    @(negedge clk);
    bus.spi_csn = 1'b0;
    bus.spi_dc  = dcv;
    bus.spi_clk = 1'b0;
    for (int i = 0; i < nb; i++) begin
      bus.spi_mosi = d[7-i];
      repeat (2) @(negedge clk);
      bus.spi_clk = 1'b1;
      tx_cyc = cyc;
      repeat (2) @(negedge clk);
      bus.spi_clk = 1'b0;
    end
    repeat (2) @(negedge clk);
    bus.spi_csn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_byte(input int nb0, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      if (n_byte > nb0) got = 1'b1;
    end
  endtask

  typedef struct {
    logic        dc;
    logic [7:0]  data;
    logic        ec;
    logic        ep;
    logic [7:0]  ex;
    logic [7:0]  ey;
    logic [15:0] ecol;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic dcv, input logic [7:0] d, input logic ec, input logic ep,
                              input logic [7:0] ex, input logic [7:0] ey, input logic [15:0] ecol);
    vq.push_back('{dcv, d, ec, ep, ex, ey, ecol});
  endfunction

  task automatic apply_range(input int lo, input int hi);
    int nb0, nc0, np0;
    bit got;
    for (int i = lo; i < hi; i++) begin
      nb0 = n_byte; nc0 = n_cmd; np0 = n_pix;
      send_bits(vq[i].data, vq[i].dc, 8);
      wait_byte(nb0, got);
      repeat (2) @(posedge clk);
      check("byte_seen",   i, got, 1);
      check("byte_count",  i, n_byte - nb0, 1);
      check("latency",     i, bv_cyc - tx_cyc, 4);
      check("byte_data",   i, s_data, vq[i].data);
      check("byte_dc",     i, s_dc, vq[i].dc);
      check("cmd_same_cyc", i, s_cmd_v, vq[i].ec);
      check("cmd_count",   i, n_cmd - nc0, vq[i].ec);
      check("pix_same_cyc", i, s_pix_v, vq[i].ep);
      check("pix_count",   i, n_pix - np0, vq[i].ep);
      check("pixel_x",     i, s_x, vq[i].ex);
      check("pixel_y",     i, s_y, vq[i].ey);
      check("pixel_color", i, s_col, vq[i].ecol);
      if (vq[i].ec) check("cmd", i, s_cmd, vq[i].data);
    end
  endtask

  task automatic stream(input int n, input int xs, input int xe, input int ys, input int ye,
                        input int x0, input int y0, input string tag,
                        output int pen_x, output int pen_y);
    int ex, ey, bad, np0, nb0;
    bit got;
    logic [15:0] col;
    ex = x0; ey = y0; bad = 0; np0 = n_pix; pen_x = -1; pen_y = -1;
    for (int k = 0; k < n; k++) begin
      col = 16'(k + 256);
      send_bits(col[15:8], 1'b1, 8);
      nb0 = n_byte;
      send_bits(col[7:0], 1'b1, 8);
      wait_byte(nb0, got);
      @(posedge clk);
      if (!got || !s_pix_v || s_x != 8'(ex) || s_y != 8'(ey) || s_col != col) bad++;
      if (k == n - 2) begin pen_x = s_x; pen_y = s_y; end
      if (ex == xe) begin
        ex = xs;
        ey = (ey == ye) ? ys : ey + 1;
      end else begin
        ex = ex + 1;
      end
    end
    check({tag, "_bad_pixels"}, 0, bad, 0);
    check({tag, "_pixel_count"}, 0, n_pix - np0, n);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int seg_a, seg_b, seg_c, seg_d;
    int nb0, nc0, np0, px, py;
    bit got;

    bus.spi_csn = 1'b1; bus.spi_clk = 1'b0; bus.spi_mosi = 1'b0; bus.spi_dc = 1'b0;

    // A: first RAMWR after reset, then CASET/RASET window and wrap
    add(0, 8'h2C, 1, 0, 8'h00, 8'h00, 16'h0000);
    add(1, 8'hF8, 0, 0, 8'h00, 8'h00, 16'h0000);
    add(1, 8'h00, 0, 1, 8'h00, 8'h00, 16'hF800);
    add(1, 8'h07, 0, 0, 8'h00, 8'h00, 16'hF800);
    add(1, 8'hE0, 0, 1, 8'h01, 8'h00, 16'h07E0);
    add(0, 8'h2A, 1, 0, 8'h01, 8'h00, 16'h07E0);
    add(1, 8'h00, 0, 0, 8'h01, 8'h00, 16'h07E0);
    add(1, 8'h10, 0, 0, 8'h01, 8'h00, 16'h07E0);
    add(1, 8'h00, 0, 0, 8'h01, 8'h00, 16'h07E0);
    add(1, 8'h11, 0, 0, 8'h01, 8'h00, 16'h07E0);
    add(0, 8'h2B, 1, 0, 8'h01, 8'h00, 16'h07E0);
    add(1, 8'h00, 0, 0, 8'h01, 8'h00, 16'h07E0);
    add(1, 8'h20, 0, 0, 8'h01, 8'h00, 16'h07E0);
    add(1, 8'h00, 0, 0, 8'h01, 8'h00, 16'h07E0);
    add(1, 8'h21, 0, 0, 8'h01, 8'h00, 16'h07E0);
    add(0, 8'h2C, 1, 0, 8'h10, 8'h20, 16'h07E0);
    add(1, 8'h12, 0, 0, 8'h10, 8'h20, 16'h07E0);
    add(1, 8'h34, 0, 1, 8'h10, 8'h20, 16'h1234);
    add(1, 8'hAB, 0, 0, 8'h10, 8'h20, 16'h1234);
    add(1, 8'hCD, 0, 1, 8'h11, 8'h20, 16'hABCD);
    add(1, 8'h55, 0, 0, 8'h11, 8'h20, 16'hABCD);
    add(1, 8'h55, 0, 1, 8'h10, 8'h21, 16'h5555);
    add(1, 8'h0F, 0, 0, 8'h10, 8'h21, 16'h5555);
    add(1, 8'h0F, 0, 1, 8'h11, 8'h21, 16'h0F0F);
    add(1, 8'hFF, 0, 0, 8'h11, 8'h21, 16'h0F0F);
    add(1, 8'hFF, 0, 1, 8'h10, 8'h20, 16'hFFFF);
    add(0, 8'h00, 1, 0, 8'h10, 8'h20, 16'hFFFF);
    add(1, 8'h77, 0, 0, 8'h10, 8'h20, 16'hFFFF);
    seg_a = vq.size();
    // B (after reset): truncated CASETs leave the window alone
    add(0, 8'h2A, 1, 0, 8'h00, 8'h00, 16'h0000);
    add(1, 8'h00, 0, 0, 8'h00, 8'h00, 16'h0000);
    add(1, 8'h05, 0, 0, 8'h00, 8'h00, 16'h0000);
    add(0, 8'h2C, 1, 0, 8'h00, 8'h00, 16'h0000);
    add(1, 8'hAA, 0, 0, 8'h00, 8'h00, 16'h0000);
    add(1, 8'h55, 0, 1, 8'h00, 8'h00, 16'hAA55);
    add(0, 8'h2A, 1, 0, 8'h00, 8'h00, 16'hAA55);
    add(1, 8'h00, 0, 0, 8'h00, 8'h00, 16'hAA55);
    add(1, 8'h05, 0, 0, 8'h00, 8'h00, 16'hAA55);
    add(1, 8'h00, 0, 0, 8'h00, 8'h00, 16'hAA55);
    add(0, 8'h2C, 1, 0, 8'h00, 8'h00, 16'hAA55);
    add(1, 8'hC3, 0, 0, 8'h00, 8'h00, 16'hAA55);
    add(1, 8'h3C, 0, 1, 8'h00, 8'h00, 16'hC33C);
    seg_b = vq.size();
    // C: program a window, then SWRESET and RAMWR
    add(0, 8'h2A, 1, 0, 8'h00, 8'h00, 16'hC33C);
    add(1, 8'h00, 0, 0, 8'h00, 8'h00, 16'hC33C);
    add(1, 8'h10, 0, 0, 8'h00, 8'h00, 16'hC33C);
    add(1, 8'h00, 0, 0, 8'h00, 8'h00, 16'hC33C);
    add(1, 8'h11, 0, 0, 8'h00, 8'h00, 16'hC33C);
    add(0, 8'h2B, 1, 0, 8'h00, 8'h00, 16'hC33C);
    add(1, 8'h00, 0, 0, 8'h00, 8'h00, 16'hC33C);
    add(1, 8'h20, 0, 0, 8'h00, 8'h00, 16'hC33C);
    add(1, 8'h00, 0, 0, 8'h00, 8'h00, 16'hC33C);
    add(1, 8'h21, 0, 0, 8'h00, 8'h00, 16'hC33C);
    add(0, 8'h01, 1, 0, 8'h00, 8'h00, 16'hC33C);
    add(0, 8'h2C, 1, 0, 8'h00, 8'h00, 16'hC33C);
    seg_c = vq.size();
    // D: single-column window at x=79, rows stay at the default 0..159
    add(0, 8'h2A, 1, 0, 8'h00, 8'h01, 16'h0150);
    add(1, 8'h00, 0, 0, 8'h00, 8'h01, 16'h0150);
    add(1, 8'h4F, 0, 0, 8'h00, 8'h01, 16'h0150);
    add(1, 8'h00, 0, 0, 8'h00, 8'h01, 16'h0150);
    add(1, 8'h4F, 0, 0, 8'h00, 8'h01, 16'h0150);
    add(0, 8'h2C, 1, 0, 8'h4F, 8'h00, 16'h0150);
    seg_d = vq.size();

    // reset state
    repeat (4) @(negedge clk);
    check("rst_byte_valid",  0, bus.byte_valid, 0);
    check("rst_byte_data",   0, bus.byte_data, 0);
    check("rst_byte_dc",     0, bus.byte_dc, 0);
    check("rst_cmd_valid",   0, bus.cmd_valid, 0);
    check("rst_cmd",         0, bus.cmd, 0);
    check("rst_pixel_valid", 0, bus.pixel_valid, 0);
    check("rst_pixel_x",     0, bus.pixel_x, 0);
    check("rst_pixel_y",     0, bus.pixel_y, 0);
    check("rst_pixel_color", 0, bus.pixel_color, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    apply_range(0, seg_a);

    // partial byte cut short by csn is discarded
    nb0 = n_byte; nc0 = n_cmd;
    send_bits(8'hA0, 1'b0, 5);
    send_bits(8'h2C, 1'b0, 8);
    wait_byte(nb0, got);
    repeat (4) @(posedge clk);
    check("partial_seen",  0, got, 1);
    check("partial_bytes", 0, n_byte - nb0, 1);
    check("partial_cmds",  0, n_cmd - nc0, 1);
    check("partial_cmd",   0, bus.cmd, 8'h2C);
    check("partial_data",  0, bus.byte_data, 8'h2C);

    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);

    apply_range(seg_a, seg_b);
    apply_range(seg_b, seg_c);

    stream(81, 0, 79, 0, 159, 0, 0, "row_wrap", px, py);
    check("row_wrap_pen_x", 0, px, 79);
    check("row_wrap_pen_y", 0, py, 0);
    check("row_wrap_last_x", 0, s_x, 0);
    check("row_wrap_last_y", 0, s_y, 1);

    apply_range(seg_c, seg_d);

    stream(161, 79, 79, 0, 159, 79, 0, "frame_wrap", px, py);
    check("frame_wrap_pen_x", 0, px, 79);
    check("frame_wrap_pen_y", 0, py, 159);
    check("frame_wrap_last_x", 0, s_x, 79);
    check("frame_wrap_last_y", 0, s_y, 0);

    // reset after a pixel hi byte: everything clears and the lone lo byte is not a pixel
    send_bits(8'h12, 1'b1, 8);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("mid_rst_byte_valid",  0, bus.byte_valid, 0);
    check("mid_rst_byte_data",   0, bus.byte_data, 0);
    check("mid_rst_byte_dc",     0, bus.byte_dc, 0);
    check("mid_rst_cmd_valid",   0, bus.cmd_valid, 0);
    check("mid_rst_cmd",         0, bus.cmd, 0);
    check("mid_rst_pixel_valid", 0, bus.pixel_valid, 0);
    check("mid_rst_pixel_x",     0, bus.pixel_x, 0);
    check("mid_rst_pixel_y",     0, bus.pixel_y, 0);
    check("mid_rst_pixel_color", 0, bus.pixel_color, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    nb0 = n_byte; np0 = n_pix;
    send_bits(8'h34, 1'b1, 8);
    wait_byte(nb0, got);
    repeat (4) @(posedge clk);
    check("lone_lo_seen",   0, got, 1);
    check("lone_lo_data",   0, bus.byte_data, 8'h34);
    check("lone_lo_no_pix", 0, n_pix - np0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
